// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types and defaults for the elastic pipeline stage (pipe_skid_stage)
//   and its storage slot (pipe_slot).
//
//   Contents:
//     stage_state_t      - occupancy of the stage (empty / one entry / full)
//     PIPE_DEFAULT_WIDTH - default payload width
//     PIPE_DEFAULT_CNT_W - default stall-counter width
//     sat_inc()          - saturating increment helper for the stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int PIPE_DEFAULT_WIDTH = 32;
   localparam int PIPE_DEFAULT_CNT_W = 16;

   // Occupancy of the stage. ST_ONE means only the main slot is live.
   // ST_FULL means main and skid are both live, and skid is the younger entry.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

   // Saturating +1 for the stall counter. The operand is limited to 32 bits,
   // which covers any sensible counter width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//   One payload register of the skid stage. It is instantiated twice, once as
//   the main slot and once as the skid slot.
//
//   Parameters:
//     WIDTH       - payload width
//     RESET_VALUE - value loaded on async reset and on synchronous clear
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-low reset
//     clear  in   synchronous clear to RESET_VALUE; takes priority over load
//     load   in   capture d on this edge
//     d      in   WIDTH  next payload
//     q      out  WIDTH  held payload
// -----------------------------------------------------------------------------
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int               WIDTH       = PIPE_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VALUE;
      end else if (clear) begin
         q <= RESET_VALUE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule : pipe_slot

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//   Elastic pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer. It is intended to sit between datapath stages (for example IF/ID
//   or ID/EX), with the hazard unit driving flush.
//
//   in_ready and out_valid are decoded from the registered occupancy state
//   only. This means there is no combinational path from out_ready to
//   in_ready. The cost is the extra skid slot, which absorbs the beat that
//   arrives in the same cycle that the downstream stalls.
//
//   Optional feature, enabled by defining the macro PIPE_SKID_STALL_CNT_EN:
//     adds the stall_count output. This is a saturating count of the cycles
//     with out_valid & ~out_ready. Only reset clears it; flush does not.
//
//   Parameters:
//     WIDTH       - payload width (default 32)
//     RESET_VALUE - payload value after reset and after flush
//     CNT_W       - stall counter width (only meaningful with the macro)
//
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     flush        in   synchronous clear; discards every held entry
//     in_valid     in   upstream has data
//     in_ready     out  stage can accept (state decode only)
//     in_data      in   WIDTH upstream payload
//     out_valid    out  main entry holds data
//     out_ready    in   downstream accepts
//     out_data     out  WIDTH main entry payload
//     stall_count  out  CNT_W (only with PIPE_SKID_STALL_CNT_EN)
// -----------------------------------------------------------------------------
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int               WIDTH       = PIPE_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = PIPE_DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_count
`endif
);

   // Elaboration-time sanity check on the counter width. This check applies
   // in both builds, so the parameter keeps the same meaning in each.
   if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("pipe_skid_stage: CNT_W must be in 1..32");
   end

   stage_state_t     state;
   stage_state_t     state_nxt;
   logic             in_fire;
   logic             out_fire;
   logic             main_ld;
   logic             skid_ld;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   // Handshake decode uses registered state only.
   assign out_valid = (state != ST_EMPTY);
   assign in_ready  = (state != ST_FULL);
   assign out_data  = main_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Next-state and slot-load decode.
   // The main slot always holds the oldest entry, so data never overtakes.
   // The skid slot is written only when a beat arrives while the single
   // held beat is stalled. On the way out of ST_FULL, the skid entry moves
   // into main.
   always_comb begin
      state_nxt = state;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
      main_d    = in_data;
      unique case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt = ST_ONE;
               main_ld   = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_ld = 1'b1;
            end else if (in_fire) begin
               state_nxt = ST_FULL;
               skid_ld   = 1'b1;
            end else if (out_fire) begin
               // main keeps its stale payload; out_valid masks it
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so the only event that can occur is
            // a drain.
            if (out_fire) begin
               state_nxt = ST_ONE;
               main_ld   = 1'b1;
               main_d    = skid_q;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Flush overrides any handshake in the same cycle. The incoming beat is
   // dropped. A beat the downstream took in that cycle has still been
   // consumed on its side.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_EMPTY;
      end else if (flush) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   pipe_slot #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .load  (main_ld),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_slot #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .load  (skid_ld),
      .d     (in_data),
      .q     (skid_q)
   );

`ifdef PIPE_SKID_STALL_CNT_EN
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [31:0] cnt_ext;
   logic [31:0] cnt_inc;

   assign cnt_ext = 32'(stall_count);
   assign cnt_inc = sat_inc(cnt_ext, CNT_MAX);

   // Counts stalled cycles, including a stalled flush cycle. Flush does
   // not clear the count, because it measures stage history rather than
   // current contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready) begin
         stall_count <= cnt_inc[CNT_W-1:0];
      end
   end
`endif

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//   Self-checking bench for pipe_skid_stage. The reference model treats the
//   stage as a FIFO of capacity 2, plus the last payload shown on out_data.
//   A short sequence of directed steps runs first, followed by a randomized
//   phase. With PIPE_SKID_STALL_CNT_EN defined, the bench also checks the
//   stall counter with CNT_W = 4.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

   localparam int          W       = 32;
   localparam logic [31:0] RV      = 32'h0;
   localparam int          TB_CW   = 4;
   localparam int          CNT_MAX = (1 << TB_CW) - 1;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
   logic [TB_CW-1:0] stall_count;
`endif

   pipe_skid_stage #(
      .WIDTH       (W),
      .RESET_VALUE (RV),
      .CNT_W       (TB_CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of live entries (oldest first), capacity 2.
   logic [31:0] mq[$];
   logic [31:0] m_last;
   int          m_cnt;
   int          n_chk;
   int          n_pass;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_last = RV;
      m_cnt  = 0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, mq.size() < 2});
      chk({tag, ".out_data"},  out_data, (mq.size() > 0) ? mq[0] : m_last);
`ifdef PIPE_SKID_STALL_CNT_EN
      chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_cnt));
`endif
   endtask

   // One clock: update the model from the inputs present at the edge, then
   // compare the DUT against the model 1 ns later.
   task automatic step(input string tag);
      bit ov;
      bit ir;
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         ov = (mq.size() > 0);
         ir = (mq.size() < 2);
         if (ov && !out_ready && m_cnt < CNT_MAX) m_cnt++;
         if (flush) begin
            mq.delete();
            m_last = RV;
         end else begin
            if (ov && out_ready) m_last = mq.pop_front();
            if (in_valid && ir) mq.push_back(in_data);
         end
      end
      #1;
      check_model(tag);
   endtask

   initial begin
      bit hold;
      n_chk     = 0;
      n_pass    = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      out_ready = 1'b0;
      model_reset();

      // ---- reset held with a valid beat offered ----
      #1;
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst.out_data",  out_data, RV);
      repeat (3) step("rst_hold");
      reset = 1'b1;
      step("first_beat");
      chk("first_beat.data", out_data, 32'hDEAD_BEEF);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step("drain0");

      // ---- streaming 1..8 back-to-back ----
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         step("stream");
         chk("stream.data", out_data, 32'(i));
         chk("stream.in_ready", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      step("stream_drain");

      // ---- backpressure: A, B fill, C held by source ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h11;
      step("bp_a");
      in_data = 32'h22;
      step("bp_b");
      chk("bp.full_in_ready", {31'd0, in_ready}, 32'd0);
      in_data = 32'h33;
      repeat (2) step("bp_c_hold");
      chk("bp.head_stable", out_data, 32'h11);
      out_ready = 1'b1;
      step("bp_out1");
      chk("bp.second", out_data, 32'h22);
      step("bp_out2");
      chk("bp.third", out_data, 32'h33);
      in_valid = 1'b0;
      step("bp_out3");
      chk("bp.empty", {31'd0, out_valid}, 32'd0);

      // ---- flush while full, with a beat offered ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      step("fl_fill1");
      in_data = 32'h66;
      step("fl_fill2");
      flush   = 1'b1;
      in_data = 32'h44;
      step("flush");
      flush = 1'b0;
      chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush.in_ready",  {31'd0, in_ready},  32'd1);
      chk("flush.out_data",  out_data, RV);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         step("post_flush");
         chk("post_flush.no44", {31'd0, out_valid && out_data == 32'h44},
             32'd0);
      end

      // ---- async reset between edges while one entry is held ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h99;
      step("ar_load");
      in_valid = 1'b0;
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("async_rst.out_data",  out_data, RV);
      step("ar_hold");
      reset = 1'b1;
      step("ar_release");

`ifdef PIPE_SKID_STALL_CNT_EN
      // ---- stall counter saturation, flush immunity, reset clear ----
      in_valid  = 1'b1;
      in_data   = 32'h77;
      out_ready = 1'b0;
      step("cnt_load");
      in_valid = 1'b0;
      repeat (20) step("cnt_stall");
      chk("cnt.saturated", 32'(stall_count), 32'(CNT_MAX));
      flush = 1'b1;
      step("cnt_flush");
      flush = 1'b0;
      chk("cnt.after_flush", 32'(stall_count), 32'(CNT_MAX));
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("cnt.after_reset", 32'(stall_count), 32'd0);
      step("cnt_rst_hold");
      reset = 1'b1;
      step("cnt_rst_release");
`endif

      // ---- randomized traffic; source holds its beat while not accepted ----
      hold = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!hold) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = $urandom;
         end
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(15) == 0);
         // Decide the hold for the next cycle from the model, before the edge.
         hold = in_valid && (mq.size() >= 2) && !flush;
         step("rand");
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_pipe_skid_stage

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline register; successor to the plain stall/clear stage register.
- Adds a valid/ready handshake and a 2-entry skid buffer, so `in_ready` has no combinational path from `out_ready`.
- Keeps the synchronous flush (clear) behaviour.
- Sits between datapath stages, e.g. IF/ID or ID/EX, with the hazard unit driving `flush`.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, 0, payload value loaded on reset and on flush (WIDTH bits).
- CNT_W, 16, stall-counter width; used only when STALL_CNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear; discards all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept; registered state only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  main entry holds data.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  main entry payload.
- stall_count  output  CNT_W  present only with STALL_CNT_EN.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register; state in {ST_EMPTY, ST_ONE, ST_FULL}.
- Output decode:
  - out_valid = (state != ST_EMPTY).
  - in_ready = (state != ST_FULL).
  - Both decode from state only.
- Reset (reset=0, asynchronous):
  - state = ST_EMPTY.
  - main = skid = RESET_VALUE.
  - out_valid=0, in_ready=1, out_data=RESET_VALUE.
  - stall_count=0.
- Flush (reset=1, flush=1 at posedge):
  - Same values as reset, except stall_count.
  - Flush beats any simultaneous in_fire/out_fire; the incoming beat is dropped.
  - The out_fire beat in the flush cycle is still counted as consumed by downstream.
- State transitions (flush=0):
  - ST_EMPTY: in_fire -> ST_ONE, main<=in_data; else hold.
  - ST_ONE, in_fire & out_fire -> ST_ONE, main<=in_data.
  - ST_ONE, in_fire & ~out_ready -> ST_FULL, skid<=in_data, main held.
  - ST_ONE, ~in_fire & out_fire -> ST_EMPTY; main keeps its last value (don't-care, not cleared).
  - ST_ONE, otherwise: hold.
  - ST_FULL: in_ready=0, so no in_fire. out_fire -> ST_ONE, main<=skid; else hold.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid when empty.
  - Sustains 1 beat/cycle when out_ready stays high.
- Ordering: strict FIFO; skid data never overtakes main data.
- Handshake rules:
  - out_data and out_valid stay stable while out_valid & ~out_ready, except on flush.
  - The upstream side must hold in_data/in_valid stable while in_valid & ~in_ready.
  - The block does not check this.
- No data loss: at most 2 entries; an in_fire into ST_ONE with out stalled always lands in skid.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_count increments each cycle with out_valid & ~out_ready.
  - Saturates at all-ones.
  - Cleared only by reset, not by flush.
- Undefined: stall_count port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] stage_state_t {ST_EMPTY=0, ST_ONE=1, ST_FULL=2}.
  - Shared localparam for default WIDTH.
- Sub-module pipe_slot:
  - WIDTH-bit register with async active-low reset to RESET_VALUE, synchronous clear, and load enable.
  - Instantiated twice (main, skid).

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, in_ready=1, out_data=0; after release, first beat appears 1 cycle after in_fire.
- Streaming: out_ready=1, feed 8 beats 1..8 back-to-back -> outputs 1..8 on consecutive cycles, in_ready constantly 1.
- Backpressure: feed A=32'h11, B=32'h22, C=32'h33 with out_ready=0 -> state ST_FULL after B, in_ready=0, C held by source; raise out_ready -> outputs 11, 22, 33 in order, no duplicates.
- Flush in ST_FULL with simultaneous in_valid=1, in_data=32'h44 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VALUE; 32'h44 never appears.
- Async reset mid-transfer: assert reset between clock edges in ST_ONE -> out_valid falls immediately, without waiting for a clock edge.
- Counter (PIPE_SKID_STALL_CNT_EN, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_count saturates at 15; flush -> stays 15; reset -> 0.
